cmd_dispatch: RTL and testbench
===============================

# cmd_dispatch

Consumer end of the 80-bit command FIFO that the host EBI slave fills. Pops one command word at a time and splits it into target address, opcode, start time and payload. Holds each command until the global sample clock reaches its start time, then hands it to the pin/DAC controllers over a valid/ready handshake. Also owns the global time counter that the host's reset-time strobe clears.

## Interface
Parameters:
- TIME_W, 32: width of time counter and start-time field (fixed at 32 by the word layout; parameter is for the counter only).
- NOP_CODE, 8'h00: opcode that is popped and discarded, never issued.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- reset_time  in  1  one-cycle strobe from EBI slave; clears time counter
- cmd_fifo_data_out  in  80  FIFO read data, valid the cycle after cmd_fifo_rd_en
- cmd_fifo_empty  in  1  FIFO empty flag
- cmd_fifo_rd_en  out  1  FIFO pop strobe
- cmd_valid  out  1  command presented to controllers
- cmd_ready  in  1  controller accepts command
- cmd_addr  out  8  target controller address
- cmd_code  out  8  opcode
- cmd_data  out  32  payload
- cur_time  out  TIME_W  global time counter
- late_count  out  16  commands whose start time had already passed when latched (saturating)

## Operation
- Word layout: [79:72] addr, [71:64] code, [63:32] start_time, [31:0] data.
- Time counter: increments by 1 every clk and wraps modulo 2^TIME_W. When reset_time is high, the next value is 0. reset_time has priority over the increment.
- FSM states:
  - IDLE: if !cmd_fifo_empty, assert cmd_fifo_rd_en for one cycle and go to LATCH; else stay.
  - LATCH: register all four fields.
    - If code == NOP_CODE, go to IDLE.
    - Else if start_time <= cur_time (unsigned), go to ISSUE. If start_time < cur_time, also increment late_count.
    - Else go to WAIT.
  - WAIT: go to ISSUE when cur_time == start_time (equality, so wrap is handled without false early issue).
  - ISSUE: cmd_valid high and fields stable until cmd_valid & cmd_ready. On that cycle go to IDLE.
- reset_time during WAIT: counter restarts at 0 and the command keeps waiting for equality. Not dropped.
- reset_time during ISSUE: no effect on the pending handshake.
- late_count saturates at 16'hFFFF.
- rd_en is never asserted when cmd_fifo_empty is high, and never while a command is held.

## Timing
- Reset values: state IDLE, cmd_fifo_rd_en 0, cmd_valid 0, cmd_addr/cmd_code/cmd_data 0, cur_time 0, late_count 0.
- Pop-to-issue latency for an already-due command: rd_en in cycle N, latch in N+1, cmd_valid in N+2.
- Earliest cmd_valid for a future command: the cycle after cur_time == start_time is observed in WAIT.
- Throughput: at most one command per 3 cycles (IDLE→LATCH→ISSUE with ready held high).
- cmd_valid, once raised, never drops before ready. Outputs are registered.
- Async rst mid-handshake: cmd_valid drops immediately. The latched command is lost; the FIFO is not rewound.

## Configuration
- CMD_DISPATCH_TIMESTAMP_EN defined: time-gated behaviour as above.
- Not defined:
  - start_time is ignored and LATCH goes directly to ISSUE (or IDLE for NOP).
  - late_count is tied to 0.
  - The time counter still runs and still honours reset_time.

## Structure
- Shared package cmd_dispatch_pkg holds:
  - the FSM state enum;
  - field bit offsets (ADDR_MSB, CODE_MSB, TIME_MSB, DATA_MSB);
  - NOP_CODE default.
- One sub-module, time_base: owns the counter and the reset_time clear, and drives cur_time.

## Test plan
- Due command: time = 100, push {8'h03, 8'h11, 32'd50, 32'hCAFEF00D} → late_count = 1, cmd_valid 2 cycles after rd_en with addr 3, code 8'h11, data CAFEF00D.
- Future command: push start_time = cur_time+20 → cmd_valid exactly when cur_time reaches start_time (+1 cycle), not earlier. late_count unchanged.
- Backpressure: hold cmd_ready = 0 for 10 cycles → cmd_valid and fields stable, no further rd_en, FIFO count unchanged. Release → single acceptance.
- NOP and empty: push code 8'h00 then a valid command → NOP popped but never issued; second command issued. With FIFO empty, rd_en stays 0 indefinitely.
- reset_time in WAIT: start_time = 500, pulse reset_time at cur_time = 300 → cur_time = 0 next cycle, issue when it reaches 500.
- Async rst asserted during ISSUE → cmd_valid 0 in the same cycle, all outputs at reset values. Build without CMD_DISPATCH_TIMESTAMP_EN → start_time = 32'hFFFFFFFF issues immediately.

Source files
------------

// File: rtl/cmd_dispatch_pkg.sv
// cmd_dispatch_pkg
// Shared definitions for the command dispatcher.
// - FSM state encoding
// - Bit positions of the fields in the 80-bit command word
// - Default NOP opcode
package cmd_dispatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_WAIT,
    S_ISSUE
  } state_t;

  localparam int CMD_W    = 80;
  localparam int ADDR_MSB = 79;
  localparam int CODE_MSB = 71;
  localparam int TIME_MSB = 63;
  localparam int DATA_MSB = 31;

  localparam logic [7:0] DEFAULT_NOP_CODE = 8'h00;

endpackage

// File: rtl/cmd_dispatch_time_base.sv
// cmd_dispatch_time_base
// Global sample-time counter for the dispatcher.
// The counter advances by one every clock and wraps.
// A reset_time strobe makes the next value zero.
// reset_time takes priority over the increment.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   reset_time in   one-cycle strobe that clears the counter
//   cur_time   out  TIME_W  current time value
module cmd_dispatch_time_base
  import cmd_dispatch_pkg::*;
#(
  parameter int TIME_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reset_time,
  output logic [TIME_W-1:0] cur_time
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_time <= '0;
    end else if (reset_time) begin
      cur_time <= '0;
    end else begin
      cur_time <= cur_time + TIME_W'(1);
    end
  end

endmodule

// File: rtl/cmd_dispatch.sv
// cmd_dispatch
// Consumer end of the host command FIFO.
// Pops one 80-bit word at a time and splits it into addr, code,
// start_time and data. NOP words are discarded. Every other command is
// presented to the pin/DAC controllers over a valid/ready handshake.
//
// Build option: CMD_DISPATCH_TIMESTAMP_EN
//   When this macro is defined, a command is held until cur_time reaches
//   its start time. late_count counts commands that were already overdue
//   when latched. When it is not defined, start_time is ignored,
//   late_count is tied to zero, and the time counter still runs.
//
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   reset_time         strobe that clears the global time counter
//   cmd_fifo_data_out  FIFO read data, valid the cycle after cmd_fifo_rd_en
//   cmd_fifo_empty     FIFO empty flag
//   cmd_fifo_rd_en     FIFO pop strobe
//   cmd_valid/ready    handshake to the controllers
//   cmd_addr/code/data fields of the command being presented
//   cur_time           global time counter
//   late_count         saturating count of overdue commands
module cmd_dispatch
  import cmd_dispatch_pkg::*;
#(
  parameter int         TIME_W   = 32,
  parameter logic [7:0] NOP_CODE = DEFAULT_NOP_CODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reset_time,
  input  logic [CMD_W-1:0]  cmd_fifo_data_out,
  input  logic              cmd_fifo_empty,
  output logic              cmd_fifo_rd_en,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [7:0]        cmd_addr,
  output logic [7:0]        cmd_code,
  output logic [31:0]       cmd_data,
  output logic [TIME_W-1:0] cur_time,
  output logic [15:0]       late_count
);

  state_t      state;
  logic [7:0]  word_addr;
  logic [7:0]  word_code;
  logic [31:0] word_start;
  logic [31:0] word_data;

  assign word_addr  = cmd_fifo_data_out[ADDR_MSB -: 8];
  assign word_code  = cmd_fifo_data_out[CODE_MSB -: 8];
  assign word_start = cmd_fifo_data_out[TIME_MSB -: 32];
  assign word_data  = cmd_fifo_data_out[DATA_MSB -: 32];

  cmd_dispatch_time_base #(
    .TIME_W(TIME_W)
  ) u_time_base (
    .clk       (clk),
    .rst       (rst),
    .reset_time(reset_time),
    .cur_time  (cur_time)
  );

  // The pop strobe is decoded from the registered state so the FIFO word
  // is already on cmd_fifo_data_out during the LATCH cycle. This gives the
  // three-cycle IDLE/LATCH/ISSUE turnaround. It is gated by the empty flag
  // and by reset so a pop can never be requested from an empty FIFO or
  // while the block is in reset.
  assign cmd_fifo_rd_en = (state == S_IDLE) && !cmd_fifo_empty && !rst;

`ifdef CMD_DISPATCH_TIMESTAMP_EN
  logic [31:0]       start_time;
  logic [TIME_W-1:0] word_due_time;
  logic [TIME_W-1:0] held_due_time;

  assign word_due_time = TIME_W'(word_start);
  assign held_due_time = TIME_W'(start_time);
`else
  logic unused_start;
  assign unused_start = ^word_start;
`endif

  // Main dispatcher FSM. All handshake outputs and fields are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_code  <= '0;
      cmd_data  <= '0;
`ifdef CMD_DISPATCH_TIMESTAMP_EN
      start_time <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!cmd_fifo_empty) begin
            state <= S_LATCH;
          end
        end

        S_LATCH: begin
          cmd_addr <= word_addr;
          cmd_code <= word_code;
          cmd_data <= word_data;
`ifdef CMD_DISPATCH_TIMESTAMP_EN
          start_time <= word_start;
          if (word_code == NOP_CODE) begin
            state <= S_IDLE;
          end else if (word_due_time <= cur_time) begin
            state     <= S_ISSUE;
            cmd_valid <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
`else
          if (word_code == NOP_CODE) begin
            state <= S_IDLE;
          end else begin
            state     <= S_ISSUE;
            cmd_valid <= 1'b1;
          end
`endif
        end

        // Equality rather than >= so that a start time just past a
        // counter wrap is not issued early.
        S_WAIT: begin
`ifdef CMD_DISPATCH_TIMESTAMP_EN
          if (cur_time == held_due_time) begin
            state     <= S_ISSUE;
            cmd_valid <= 1'b1;
          end
`else
          state     <= S_ISSUE;
          cmd_valid <= 1'b1;
`endif
        end

        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef CMD_DISPATCH_TIMESTAMP_EN
  // A command is counted as late when its start time is strictly earlier
  // than the time at which it is latched. The count saturates at its
  // maximum value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      late_count <= '0;
    end else if ((state == S_LATCH) && (word_code != NOP_CODE) &&
                 (word_due_time < cur_time) && (late_count != 16'hFFFF)) begin
      late_count <= late_count + 16'd1;
    end
  end
`else
  assign late_count = '0;
`endif

endmodule

// File: tb/tb_cmd_dispatch.sv
// tb_cmd_dispatch
// Randomised scoreboard bench for cmd_dispatch.
// A behavioural FIFO feeds the DUT.
// A reference model follows the command rules and queues the expected
// issue (fields, issue cycle, late count) whenever a word is popped.
// A monitor compares every presented command against that queue.
// Inputs change 2ns after the rising edge.
// Everything is sampled on the falling edge.
module tb_cmd_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reset_time = 1'b0;
  logic [79:0] cmd_fifo_data_out = '0;
  logic        cmd_fifo_empty = 1'b1;
  logic        cmd_fifo_rd_en;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [7:0]  cmd_addr;
  logic [7:0]  cmd_code;
  logic [31:0] cmd_data;
  logic [31:0] cur_time;
  logic [15:0] late_count;

  cmd_dispatch #(
    .TIME_W  (32),
    .NOP_CODE(8'h00)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .reset_time       (reset_time),
    .cmd_fifo_data_out(cmd_fifo_data_out),
    .cmd_fifo_empty   (cmd_fifo_empty),
    .cmd_fifo_rd_en   (cmd_fifo_rd_en),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_addr         (cmd_addr),
    .cmd_code         (cmd_code),
    .cmd_data         (cmd_data),
    .cur_time         (cur_time),
    .late_count       (late_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  code;
    logic [31:0] data;
    int          rise;
    logic [15:0] late;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [79:0] host_q[$];
  logic [79:0] fifo[$];
  exp_t        sb[$];

  logic [31:0] mtime = '0;
  logic [31:0] mtime_next;
  logic [15:0] late_exp = '0;
  logic        busy = 1'b0;
  logic        nop_pending = 1'b0;
  logic        waiting = 1'b0;
  logic        active = 1'b0;
  logic [31:0] wait_start;
  int          wait_from;
  exp_t        wait_entry;
  exp_t        new_entry;
  exp_t        cur;
  logic [79:0] popped;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=timeout expected=event at %0t", name, $time);
  endtask

  task automatic syncCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] code,
                               input logic [31:0] start, input logic [31:0] data);
    host_q.push_back({addr, code, start, data});
  endtask

  task automatic pulseResetTime();
    syncCycle();
    reset_time = 1'b1;
    syncCycle();
    reset_time = 1'b0;
  endtask

  task automatic waitTime(input logic [31:0] target, input int budget);
    int n;
    n = 0;
    while (mtime != target && n < budget) begin
      syncCycle();
      n++;
    end
    if (mtime != target) failNow("wait_time");
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(host_q.size() == 0 && fifo.size() == 0 && !busy && !waiting &&
                 sb.size() == 0 && !active) && n < budget);
    if (n >= budget) failNow("drain");
    checkOutput("late_count_idle", 64'(late_count), 64'(late_exp));
  endtask

  // Cycle counter, used to express the expected issue cycle.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural command FIFO. It pops on rd_en and presents the word on
  // the following cycle. Words pushed by the stimulus enter the FIFO at
  // the next edge.
  always @(posedge clk) begin
    if (cmd_fifo_rd_en && fifo.size() > 0) cmd_fifo_data_out <= fifo.pop_front();
    while (host_q.size() > 0) fifo.push_back(host_q.pop_front());
    cmd_fifo_empty <= (fifo.size() == 0);
  end

  // Reference model. It tracks the expected time and the legality of
  // pops. When a word is popped, it decides from the rules when that
  // command must appear.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("cur_time_rst", 64'(cur_time), 64'd0);
      mtime       = '0;
      late_exp    = '0;
      busy        = 1'b0;
      nop_pending = 1'b0;
      waiting     = 1'b0;
    end else begin
      checkOutput("cur_time", 64'(cur_time), 64'(mtime));
      if (cmd_fifo_rd_en && (busy || cmd_fifo_empty)) failNow("rd_en_illegal");
      if (nop_pending) begin
        busy        = 1'b0;
        nop_pending = 1'b0;
      end
      if (waiting && cyc >= wait_from && mtime == wait_start) begin
        wait_entry.rise = cyc + 1;
        sb.push_back(wait_entry);
        waiting = 1'b0;
      end
      if (cmd_valid && cmd_ready) busy = 1'b0;
      mtime_next = reset_time ? 32'd0 : mtime + 32'd1;
      if (cmd_fifo_rd_en && !cmd_fifo_empty && !busy) begin
        if (fifo.size() == 0) begin
          failNow("pop_from_empty_model");
        end else begin
          popped = fifo[0];
          busy   = 1'b1;
          new_entry.addr = popped[79:72];
          new_entry.code = popped[71:64];
          new_entry.data = popped[31:0];
          new_entry.rise = cyc + 2;
          if (popped[71:64] == 8'h00) begin
            nop_pending = 1'b1;
          end else begin
`ifdef CMD_DISPATCH_TIMESTAMP_EN
            if (popped[63:32] <= mtime_next) begin
              if (popped[63:32] < mtime_next && late_exp != 16'hFFFF) late_exp = late_exp + 16'd1;
              new_entry.late = late_exp;
              sb.push_back(new_entry);
            end else begin
              new_entry.late = late_exp;
              wait_entry = new_entry;
              wait_start = popped[63:32];
              wait_from  = cyc + 2;
              waiting    = 1'b1;
            end
`else
            new_entry.late = 16'd0;
            sb.push_back(new_entry);
`endif
          end
        end
      end
      mtime = mtime_next;
    end
  end

  // Monitor. It pops the expected command when cmd_valid rises, checks
  // that the fields hold until acceptance, and checks the late count.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      active = 1'b0;
    end else begin
      if (cmd_valid && !active) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_issue", 64'(cmd_valid), 64'd0);
        end else begin
          cur    = sb.pop_front();
          active = 1'b1;
          checkOutput("issue_cycle", 64'(cyc), 64'(cur.rise));
          checkOutput("addr", 64'(cmd_addr), 64'(cur.addr));
          checkOutput("code", 64'(cmd_code), 64'(cur.code));
          checkOutput("data", 64'(cmd_data), 64'(cur.data));
        end
      end else if (cmd_valid && active) begin
        checkOutput("hold_addr", 64'(cmd_addr), 64'(cur.addr));
        checkOutput("hold_code", 64'(cmd_code), 64'(cur.code));
        checkOutput("hold_data", 64'(cmd_data), 64'(cur.data));
      end else if (!cmd_valid && active) begin
        checkOutput("valid_dropped", 64'(cmd_valid), 64'd1);
        active = 1'b0;
      end else if (sb.size() > 0 && cyc > sb[0].rise) begin
        failNow("issue_missing");
        cur = sb.pop_front();
      end
      if (cmd_valid && cmd_ready && active) begin
        checkOutput("late_count", 64'(late_count), 64'(cur.late));
        active = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  code;
    logic [31:0] base;
    int          n;

    // Reset values
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_rd_en", 64'(cmd_fifo_rd_en), 64'd0);
    checkOutput("rst_valid", 64'(cmd_valid), 64'd0);
    checkOutput("rst_addr", 64'(cmd_addr), 64'd0);
    checkOutput("rst_code", 64'(cmd_code), 64'd0);
    checkOutput("rst_data", 64'(cmd_data), 64'd0);
    checkOutput("rst_late", 64'(late_count), 64'd0);
    syncCycle();
    rst = 1'b0;

    // Already-due command
    pulseResetTime();
    waitTime(32'd100, 300);
    applyStimulus(8'h03, 8'h11, 32'd50, 32'hCAFEF00D);
    waitIdle(200);

    // Future command
    syncCycle();
    applyStimulus(8'h05, 8'h22, mtime + 32'd20, 32'h0BADBEEF);
    waitIdle(200);

    // Backpressure
    cmd_ready = 1'b0;
    syncCycle();
    applyStimulus(8'h10, 8'h44, 32'd0, 32'h11112222);
    syncCycle();
    applyStimulus(8'h11, 8'h45, 32'd0, 32'h33334444);
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_valid && n < 20);
    if (!cmd_valid) failNow("bp_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_valid_held", 64'(cmd_valid), 64'd1);
      checkOutput("bp_fifo_count", 64'(fifo.size()), 64'd1);
    end
    syncCycle();
    cmd_ready = 1'b1;
    waitIdle(200);

    // NOP followed by a real command
    syncCycle();
    applyStimulus(8'h20, 8'h00, 32'd0, 32'hDEADDEAD);
    applyStimulus(8'h21, 8'h66, 32'd0, 32'h55667788);
    waitIdle(200);

    // reset_time while a command is waiting
    pulseResetTime();
    applyStimulus(8'h30, 8'h77, 32'd500, 32'h99990000);
    waitTime(32'd300, 1000);
    reset_time = 1'b1;
    syncCycle();
    reset_time = 1'b0;
    waitIdle(2000);

    // Randomised traffic
    pulseResetTime();
    for (int i = 0; i < 400; i++) begin
      syncCycle();
      cmd_ready  = ($urandom_range(0, 3) != 0);
      reset_time = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) begin
        code = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        base = (mtime > 32'd40) ? mtime - 32'd40 : 32'd0;
        applyStimulus(8'($urandom), code, base + 32'($urandom_range(0, 100)), $urandom);
      end
    end
    syncCycle();
    reset_time = 1'b0;
    cmd_ready  = 1'b1;
    waitIdle(5000);

    // Asynchronous reset during a pending handshake
    cmd_ready = 1'b0;
    syncCycle();
    applyStimulus(8'h7A, 8'h33, 32'd0, 32'h12345678);
    n = 0;
    do begin @(negedge clk); n++; end while (!cmd_valid && n < 20);
    if (!cmd_valid) failNow("arst_valid");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_valid", 64'(cmd_valid), 64'd0);
    checkOutput("arst_rd_en", 64'(cmd_fifo_rd_en), 64'd0);
    checkOutput("arst_addr", 64'(cmd_addr), 64'd0);
    checkOutput("arst_code", 64'(cmd_code), 64'd0);
    checkOutput("arst_data", 64'(cmd_data), 64'd0);
    checkOutput("arst_time", 64'(cur_time), 64'd0);
    checkOutput("arst_late", 64'(late_count), 64'd0);
    @(negedge clk);
    @(negedge clk);
    syncCycle();
    rst       = 1'b0;
    cmd_ready = 1'b1;

    // Empty FIFO: no pops
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("idle_rd_en", 64'(cmd_fifo_rd_en), 64'd0);
    end

`ifndef CMD_DISPATCH_TIMESTAMP_EN
    // Without time gating, even the largest start time issues at once
    syncCycle();
    applyStimulus(8'h42, 8'h24, 32'hFFFFFFFF, 32'hA5A5A5A5);
    waitIdle(50);
`endif

    waitIdle(100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
